// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type, PC step and counter-width helper for the fetch queue unit.
// Contents:
//   state_t  - fetch FSM states (IDLE, RUN)
//   PC_STEP  - byte increment between sequential instruction fetches
//   cnt_w()  - width of a counter that must hold 0..depth inclusive
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PC_STEP = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead FIFO holding {pc, instruction} records for decode.
// Ports:
//   clock, reset_n    - clock, asynchronous active-low reset
//   push, push_data   - write push_data at the tail
//   pop               - drop the head entry (caller guarantees valid)
//   flush             - empty the queue; overrides push and pop
//   head_data         - head entry, driven straight from storage
//   valid             - queue not empty
//   count             - number of stored entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [W-1:0]            head_data,
    output logic                    valid,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data = mem_q[rd_q];
    assign valid     = (cnt_q != '0);
    assign count     = cnt_q;

    // The fetch credit rule keeps requests in flight plus stored words within DEPTH.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && !flush && cnt_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(pop && !flush && cnt_q == '0));

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: pipelined instruction fetch with a DEPTH-entry queue toward decode.
// Ports:
//   clock, reset_n                    - clock, asynchronous active-low reset
//   fetch_en                          - permits new memory requests
//   redirect_valid, redirect_addr     - one-cycle redirect to a new fetch PC
//   imem_req_valid/ready/addr         - request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data     - in-order, never back-pressured responses
//   inst_valid/ready, inst_data/pc    - queue head toward decode
//   pc_out                            - next PC to be requested
//   align_fault                       - sticky misaligned-redirect trap (FETCH_ALIGN_TRAP_EN only)
// Build option: define FETCH_ALIGN_TRAP_EN to trap misaligned redirects instead of
// silently clearing the low address bits.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_ALIGN_TRAP_EN
    ,
    output logic              align_fault
`endif
);

    localparam int                CW      = cnt_w(DEPTH);
    localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CW-1:0]            outst_q, outst_d, disc_q, disc_d, count;
    logic                     fire, push, pop, bad_align, trapped;
    logic [ADDR_W+DATA_W-1:0] head;

    assign target = redirect_addr & ~ADDR_W'(3);

`ifdef FETCH_ALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign bad_align = redirect_valid && (redirect_addr[1:0] != 2'b00);
    always_comb fault_d = fault_q || bad_align;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) fault_q <= 1'b0;
        else          fault_q <= fault_d;
    end
    assign trapped     = fault_q;
    assign align_fault = fault_q;
`else
    assign bad_align = 1'b0;
    assign trapped   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A trap pins the unit in IDLE until reset.
    always_comb state_d = (trapped || bad_align) ? IDLE : (fetch_en ? RUN : IDLE);

    // Credit rule: never let in-flight requests plus queued words exceed DEPTH.
    always_comb begin
        imem_req_valid = (state_q == RUN) && !redirect_valid &&
                         ((CW + 1)'(outst_q) + (CW + 1)'(count) < DEPTH_C);
        imem_req_addr  = pc_q;
        pc_out         = pc_q;
    end

    always_comb begin
        fire     = imem_req_valid && imem_req_ready;
        pop      = inst_valid && inst_ready && !redirect_valid;
        push     = imem_rsp_valid && (disc_q == '0) && !redirect_valid;
        outst_d  = outst_q + CW'(fire) - CW'(imem_rsp_valid);
        pc_d     = fire ? pc_q + STEP : pc_q;
        rsp_pc_d = push ? rsp_pc_q + STEP : rsp_pc_q;
        disc_d   = (imem_rsp_valid && disc_q != '0) ? disc_q - CW'(1) : disc_q;
        // Every request still in flight after a redirect returns a stale word.
        if (redirect_valid) begin
            pc_d     = target;
            rsp_pc_d = target;
            disc_d   = outst_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            disc_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
        end
    end

    fetch_queue #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .valid     (inst_valid),
        .count     (count)
    );

    assign {inst_pc, inst_data} = head;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed table-driven and sequence checks of fetch_queue_unit
// against an in-order instruction memory model with programmable latency.
module tb_fetch_queue_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_en, redirect_valid, imem_req_ready, imem_rsp_valid, inst_ready;
    logic [31:0] redirect_addr, imem_rsp_data;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_req_addr, inst_data, inst_pc, pc_out;
`ifdef FETCH_ALIGN_TRAP_EN
    logic        align_fault;
`endif

    fetch_queue_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .pc_out         (pc_out)
`ifdef FETCH_ALIGN_TRAP_EN
        ,
        .align_fault    (align_fault)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: responses are driven at the falling edge, accepted requests are
    // sampled 1 ns before the rising edge so they see the final inputs of the cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pq[$];
    int   cyc   = 0;
    int   lat   = 1;
    int   nfire = 0;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = rom(pq[0].addr);
                void'(pq.pop_front());
            end
            #4;
            if (reset_n && imem_req_valid && imem_req_ready) begin
                pq.push_back('{addr: imem_req_addr, due: cyc + lat});
                nfire++;
            end
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_req_ready = 1'b1;
        pq.delete();
        nfire = 0;
        #1;
        chk("reset req_valid", imem_req_valid, 0);
        chk("reset req_addr", imem_req_addr, 0);
        chk("reset pc_out", pc_out, 0);
        chk("reset inst_valid", inst_valid, 0);
        chk("reset inst_data", inst_data, 0);
        chk("reset inst_pc", inst_pc, 0);
`ifdef FETCH_ALIGN_TRAP_EN
        chk("reset align_fault", align_fault, 0);
`endif
        step();
        step();
        reset_n = 1'b1;
    endtask

    logic [31:0] seen[$];

    task automatic collect(input string name, input int n);
        seen.delete();
        for (int k = 0; k < 60 && seen.size() < n; k++) begin
            if (inst_valid && inst_ready) begin
                seen.push_back(inst_pc);
                chk({name, " data"}, inst_data, rom(inst_pc));
            end
            step();
        end
        if (seen.size() < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d words expected %0d", name, seen.size(), n);
        end
    endtask

    typedef struct {
        logic        fe, rdy;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;
    vec_t vec[19];

    initial begin
        // Latency 1 streaming, back-pressure from decode, then fetch_en dropped mid-stream.
        vec[0]  = '{1, 1, 0, 32'h00, 0, 32'h00};
        vec[1]  = '{1, 1, 1, 32'h00, 0, 32'h00};
        vec[2]  = '{1, 1, 1, 32'h04, 0, 32'h00};
        vec[3]  = '{1, 1, 1, 32'h08, 1, 32'h00};
        vec[4]  = '{1, 1, 1, 32'h0C, 1, 32'h04};
        vec[5]  = '{1, 1, 1, 32'h10, 1, 32'h08};
        vec[6]  = '{1, 0, 1, 32'h14, 1, 32'h0C};
        vec[7]  = '{1, 0, 1, 32'h18, 1, 32'h0C};
        vec[8]  = '{1, 0, 0, 32'h1C, 1, 32'h0C};
        vec[9]  = '{1, 0, 0, 32'h1C, 1, 32'h0C};
        vec[10] = '{1, 1, 0, 32'h1C, 1, 32'h0C};
        vec[11] = '{1, 1, 1, 32'h1C, 1, 32'h10};
        vec[12] = '{1, 1, 1, 32'h20, 1, 32'h14};
        vec[13] = '{1, 1, 1, 32'h24, 1, 32'h18};
        vec[14] = '{0, 1, 1, 32'h28, 1, 32'h1C};
        vec[15] = '{0, 1, 0, 32'h2C, 1, 32'h20};
        vec[16] = '{0, 1, 0, 32'h2C, 1, 32'h24};
        vec[17] = '{0, 1, 0, 32'h2C, 1, 32'h28};
        vec[18] = '{0, 1, 0, 32'h2C, 0, 32'h00};

        do_reset();
        lat = 1;
        for (int i = 0; i < 19; i++) begin
            fetch_en   = vec[i].fe;
            inst_ready = vec[i].rdy;
            #1;
            chk($sformatf("v%0d req_valid", i), imem_req_valid, vec[i].rv);
            chk($sformatf("v%0d req_addr", i), imem_req_addr, vec[i].ra);
            chk($sformatf("v%0d inst_valid", i), inst_valid, vec[i].iv);
            if (vec[i].iv) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, vec[i].ipc);
                chk($sformatf("v%0d inst_data", i), inst_data, rom(vec[i].ipc));
            end
            step();
        end

        // Latency 3 with decode stalled: credits cap issue at DEPTH requests.
        do_reset();
        lat        = 3;
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        repeat (20) step();
        chk("stall fires", nfire, 4);
        chk("stall req_valid", imem_req_valid, 0);
        chk("stall req_addr", imem_req_addr, 32'h10);
        chk("stall head pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        collect("stall resume", 6);
        for (int k = 0; k < 6 && k < seen.size(); k++)
            chk($sformatf("stall resume pc%0d", k), seen[k], 32'(4 * k));

        // Redirect to 0x40 with two requests in flight.
        do_reset();
        lat        = 3;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        step();
        chk("redir issue0", imem_req_valid, 1);
        step();
        chk("redir issue1", imem_req_valid, 1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        #1;
        chk("redir cycle req_valid", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir req_valid", imem_req_valid, 1);
        chk("redir req_addr", imem_req_addr, 32'h40);
        chk("redir pc_out", pc_out, 32'h40);
        collect("redir", 2);
        if (seen.size() >= 2) begin
            chk("redir pc0", seen[0], 32'h40);
            chk("redir pc1", seen[1], 32'h44);
        end

        // Redirect coinciding with a response and a pop.
        do_reset();
        lat        = 1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        repeat (6) step();
        chk("collide pre", {inst_valid, imem_rsp_valid}, 2'b11);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80;
        #1;
        chk("collide req_valid", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("collide empty", inst_valid, 0);
        chk("collide req_valid next", imem_req_valid, 1);
        chk("collide req_addr", imem_req_addr, 32'h80);
        collect("collide", 1);
        if (seen.size() >= 1) chk("collide pc0", seen[0], 32'h80);

        // Memory not ready for 5 cycles: address holds.
        do_reset();
        lat        = 1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        repeat (4) step();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("mstall%0d req_valid", k), imem_req_valid, 1);
            chk($sformatf("mstall%0d req_addr", k), imem_req_addr, 32'h0C);
            chk($sformatf("mstall%0d pc_out", k), pc_out, 32'h0C);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        chk("mstall advance", imem_req_addr, 32'h10);

`ifdef FETCH_ALIGN_TRAP_EN
        // Misaligned redirect traps and halts fetch until reset.
        do_reset();
        lat        = 1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h42;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("trap fault", align_fault, 1);
        chk("trap inst_valid", inst_valid, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("trap%0d req_valid", k), imem_req_valid, 0);
            chk($sformatf("trap%0d fault", k), align_fault, 1);
            step();
        end
        do_reset();
        fetch_en = 1'b1;
        step();
        step();
        chk("trap cleared req_valid", imem_req_valid, 1);
`else
        // Misaligned redirect silently clears the low address bits.
        do_reset();
        lat        = 1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h53;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("lowbits req_addr", imem_req_addr, 32'h50);
        collect("lowbits", 2);
        if (seen.size() >= 2) begin
            chk("lowbits pc0", seen[0], 32'h50);
            chk("lowbits pc1", seen[1], 32'h54);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
